// File: rtl/regfile_pkg.sv
// Shared types, default sizes and the byte-merge helper for the multi-port register file.
package regfile_pkg;

  localparam int REGFILE_WIDTH = 32;
  localparam int REGFILE_DEPTH = 32;
  localparam int REGFILE_NRD   = 2;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  // Byte-lane merge: one lane of a byte-enabled write.
  function automatic logic [7:0] merge_be(input logic [7:0] old_byte,
                                          input logic [7:0] new_byte,
                                          input logic       be);
    return be ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks a pointer over every entry, one per cycle, while busy is high.
//   state    | meaning
//   ST_IDLE  | waiting for i_clr_req
//   ST_CLEAR | zeroing entry r_ptr this cycle; pulses o_clr_done after the last entry
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH      = REGFILE_DEPTH,
  parameter int ADDR_WIDTH = $clog2(REGFILE_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clr_req,
  output logic                  o_busy,
  output logic                  o_clr_done,
  output logic                  o_clr_en,
  output logic [ADDR_WIDTH-1:0] o_clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-1:0] w_ptr_nxt;
  logic                  r_done;
  logic                  w_done_nxt;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_clr_req) begin
          w_state_nxt = ST_CLEAR;
          w_ptr_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        // clr_req is deliberately not looked at here: no restart mid-clear
        if (r_ptr == LAST_ADDR) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_ptr_nxt = r_ptr + ADDR_WIDTH'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  assign o_busy     = (r_state == ST_CLEAR);
  assign o_clr_en   = (r_state == ST_CLEAR);
  assign o_clr_addr = r_ptr;
  assign o_clr_done = r_done;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: byte-enabled write port, NRD registered read ports, flat debug bus,
// built-in clear sequencer. Optional macro REGFILE_BYPASS_EN forwards same-edge writes to reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int WIDTH      = REGFILE_WIDTH,
  parameter  int DEPTH      = REGFILE_DEPTH,
  parameter  int NRD        = REGFILE_NRD,
  parameter  int ZERO_REG   = 1,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int BE_WIDTH   = WIDTH / 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_wr_en,
  output logic                      o_wr_ready,
  input  logic [ADDR_WIDTH-1:0]     i_wr_addr,
  input  logic [WIDTH-1:0]          i_wr_data,
  input  logic [BE_WIDTH-1:0]       i_wr_be,
  input  logic [NRD-1:0]            i_rd_en,
  input  logic [NRD*ADDR_WIDTH-1:0] i_rd_addr,
  output logic [NRD*WIDTH-1:0]      o_rd_data,
  output logic [NRD-1:0]            o_rd_valid,
  input  logic                      i_clr_req,
  output logic                      o_busy,
  output logic                      o_clr_done,
  output logic [WIDTH*DEPTH-1:0]    o_regs_bus
);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic                  w_busy;
  logic                  w_clr_en;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic                  w_wr_fire;
  logic                  w_wr_hit;
  logic [WIDTH-1:0]      w_wr_old;
  logic [WIDTH-1:0]      w_wr_merged;

  regfile_clr_seq #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clr_seq (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr_req  (i_clr_req),
    .o_busy     (w_busy),
    .o_clr_done (o_clr_done),
    .o_clr_en   (w_clr_en),
    .o_clr_addr (w_clr_addr)
  );

  assign o_busy     = w_busy;
  assign o_wr_ready = !w_busy;
  assign w_wr_fire  = i_wr_en && !w_busy;
  assign w_wr_hit   = (32'(i_wr_addr) < 32'(DEPTH)) &&
                      !((ZERO_REG != 0) && (i_wr_addr == '0));
  assign w_wr_old   = w_wr_hit ? r_mem[i_wr_addr] : '0;

  always_comb begin
    w_wr_merged = w_wr_old;
    for (int k = 0; k < BE_WIDTH; k++) begin
      w_wr_merged[8*k +: 8] = merge_be(w_wr_old[8*k +: 8], i_wr_data[8*k +: 8], i_wr_be[k]);
    end
  end

  // Clear and write never coincide: writes are refused while the sequencer is busy.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_clr_en) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_fire && w_wr_hit) begin
      r_mem[i_wr_addr] <= w_wr_merged;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_ok;
    logic [WIDTH-1:0]      w_val;
    logic [WIDTH-1:0]      r_data;
    logic                  r_valid;

    assign w_addr = i_rd_addr[ADDR_WIDTH*g +: ADDR_WIDTH];
    assign w_ok   = (32'(w_addr) < 32'(DEPTH)) && !((ZERO_REG != 0) && (w_addr == '0));

    always_comb begin
      w_val = '0;
      if (w_ok) begin
        w_val = r_mem[w_addr];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_fire && w_wr_hit && (i_wr_addr == w_addr)) begin
          w_val = w_wr_merged;
        end
`endif
      end
    end

    always_ff @(posedge i_clk) begin
      if (!i_rst) begin
        r_data  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_valid <= i_rd_en[g];
        if (i_rd_en[g]) begin
          r_data <= w_val;
        end
      end
    end

    assign o_rd_data[WIDTH*g +: WIDTH] = r_data;
    assign o_rd_valid[g]               = r_valid;
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_bus
    assign o_regs_bus[WIDTH*e +: WIDTH] = r_mem[e];
  end

endmodule
